// File: rtl/pulse_stretch_if.sv
// Purpose : bundles the event strobe, overflow clear and stretched-pulse status
//           signals exchanged between an event source and pulse_stretch.
// Ports   : pulse_in, clear_ovf (source -> stretcher); level_out, busy,
//           pend_cnt[PEND_W], ovf (stretcher -> source).
//           master = event source side, slave = pulse_stretch side.
interface pulse_stretch_if #(
  parameter int PEND_W = 3
);
  logic              pulse_in;
  logic              clear_ovf;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;

  modport master (
    output pulse_in,
    output clear_ovf,
    input  level_out,
    input  busy,
    input  pend_cnt,
    input  ovf
  );

  modport slave (
    input  pulse_in,
    input  clear_ovf,
    output level_out,
    output busy,
    output pend_cnt,
    output ovf
  );
endinterface

// File: rtl/pulse_stretch.sv
// Purpose : stretches single-cycle event strobes into HOLD-cycle level pulses
//           separated by at least GAP low cycles; events arriving mid-pulse
//           are queued in a saturating counter and replayed in order.
// Latency : level_out rises on the same edge that samples an event in IDLE.
// Backpressure: none on pulse_in; events beyond 2^PEND_W-1 queued are dropped
//           and flagged by the sticky ovf (cleared by clear_ovf, set wins).
// Ports   : clk, rst (async, active-high); bus (slave modport): pulse_in,
//           clear_ovf in; level_out, busy, pend_cnt, ovf out.
module pulse_stretch #(
  parameter int HOLD   = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  pulse_stretch_if.slave bus
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W  = (MAX_HG > 1) ? $clog2(MAX_HG) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic has_pend;
  logic do_start;
  logic consume;
  logic enqueue;
  logic drop;

  assign has_pend = (pend_q != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pulse_in || has_pend) begin
          do_start = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_LOW: begin
        // Last low cycle chains straight into the next pulse so back-to-back
        // pulses see exactly GAP low cycles, with no extra IDLE cycle.
        if (cnt_q == '0) begin
          if (has_pend || bus.pulse_in) begin
            do_start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (do_start) begin
      state_d = S_HIGH;
      cnt_d   = HOLD_LOAD;
    end
  end

  // Output / bookkeeping logic
  always_comb begin
    level_d = (state_d == S_HIGH);

    // The queue has priority: a start consumes a queued event if one exists,
    // and a strobe only bypasses the queue when it is empty at a start.
    consume = do_start && has_pend;
    enqueue = bus.pulse_in && !(do_start && !has_pend);
    drop    = enqueue && !consume && (pend_q == PEND_MAX);

    pend_d = pend_q;
    if (consume && !enqueue) begin
      pend_d = pend_q - PEND_ONE;
    end else if (enqueue && !consume && !drop) begin
      pend_d = pend_q + PEND_ONE;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.pend_cnt  = pend_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Purpose : self-checking bench for pulse_stretch using a timeline-based
//           reference model and a scoreboard queue drained by a monitor.
// Ports   : none (top-level bench).
module tb_pulse_stretch;

  localparam int HOLD   = 4;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk;
  logic rst;

  pulse_stretch_if #(.PEND_W(PEND_W)) bus ();

  pulse_stretch #(
    .HOLD  (HOLD),
    .GAP   (GAP),
    .PEND_W(PEND_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit level;
    bit busy;
    int pend;
    bit ovf;
    int edge_idx;
  } exp_t;

  exp_t sb_q[$];

  int checks     = 0;
  int failures   = 0;
  int exp_starts = 0;
  int dut_rises  = 0;

  // Reference model: a pulse starting at edge t0 owns edges [t0, t0+HOLD+GAP);
  // a new pulse may start at any edge at or after that window ends.
  int m_edge;
  int m_t0;
  int m_free_at;
  int m_pend;
  bit m_ovf;
  bit m_started;

  task automatic chk(input string name, input int act, input int exp_v, input int at);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, at);
    end
  endtask

  task automatic model_reset();
    m_edge    = -1;
    m_t0      = 0;
    m_free_at = 0;
    m_pend    = 0;
    m_ovf     = 1'b0;
    m_started = 1'b0;
  endtask

  // Drive one cycle of stimulus and push the post-edge expectation.
  task automatic step(input bit pin, input bit clr);
    bit   start, consume, enq, drop;
    exp_t x;
    @(negedge clk);
    bus.pulse_in  = pin;
    bus.clear_ovf = clr;
    m_edge++;
    start   = (m_edge >= m_free_at) && (m_pend > 0 || pin);
    consume = start && (m_pend > 0);
    enq     = pin && !(start && m_pend == 0);
    drop    = 1'b0;
    if (consume && !enq) m_pend--;
    else if (enq && !consume) begin
      if (m_pend == PMAX) drop = 1'b1;
      else m_pend++;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (start) begin
      m_t0      = m_edge;
      m_free_at = m_edge + HOLD + GAP;
      m_started = 1'b1;
      exp_starts++;
    end
    x.level    = m_started && ((m_edge - m_t0) < HOLD);
    x.busy     = (m_edge < m_free_at);
    x.pend     = m_pend;
    x.ovf      = m_ovf;
    x.edge_idx = m_edge;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, int'(bus.level_out), 0, m_edge);
    chk({tag, "_busy"},  int'(bus.busy),      0, m_edge);
    chk({tag, "_pend"},  int'(bus.pend_cnt),  0, m_edge);
    chk({tag, "_ovf"},   int'(bus.ovf),       0, m_edge);
  endtask

  // Monitor: one scoreboard entry per clock edge, sampled just after it.
  initial begin
    exp_t x;
    bit   prev_level;
    prev_level = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("level_out", int'(bus.level_out), int'(x.level), x.edge_idx);
        chk("busy",      int'(bus.busy),      int'(x.busy),  x.edge_idx);
        chk("pend_cnt",  int'(bus.pend_cnt),  x.pend,        x.edge_idx);
        chk("ovf",       int'(bus.ovf),       int'(x.ovf),   x.edge_idx);
        if (bus.level_out && !prev_level) dut_rises++;
        prev_level = bus.level_out;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.pulse_in  = 1'b0;
    bus.clear_ovf = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Isolated event at edge 10
    idle(10);
    step(1'b1, 1'b0);
    idle(12);

    // Burst of three consecutive events
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(25);

    // Overflow: five events in the first HIGH window, then clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(30);
    step(1'b0, 1'b1);
    idle(3);

    // Drop and clear on the same edge: set must win
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    idle(30);
    step(1'b0, 1'b1);
    idle(3);

    // Arrival on the last LOW cycle with an empty queue
    step(1'b1, 1'b0);
    idle(HOLD + GAP - 1);
    step(1'b1, 1'b0);
    idle(12);

    // Same arrival with a saturated queue: consume and enqueue cancel
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0);
    idle(35);

    // Asynchronous reset mid-HIGH with two events queued
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst           = 1'b1;
    bus.pulse_in  = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(20);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5));
    end
    idle(40);

    @(posedge clk);
    #2;
    chk("sb_drained",  sb_q.size(), 0, m_edge);
    chk("pulse_count", dut_rises, exp_starts, m_edge);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
